spi_flash_responder: RTL and testbench

SPI-flash responder that emulates the subset of a serial NOR flash the bootloader drives over `spi_cs`/`spi_sck`/`spi_mosi`/`spi_miso`. It is the target end of that link: it samples the master's SPI mode-0 signals with the 48 MHz system clock, decodes flash opcodes, and serves reads and page programs from an external byte-wide memory port. It is used as an on-board flash stand-in and as a synthesizable bench target for the bootloader's SPI master.

---
 rtl/spi_flash_pkg.sv | 26 ++
 rtl/spi_flash_responder_sync.sv | 43 ++++
 rtl/spi_flash_responder.sv | 184 ++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI NOR flash responder:
// opcodes, status-register bit positions and the transaction FSM states.
package spi_flash_pkg;

   localparam logic [7:0] OP_PROG = 8'h02;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_RDID = 8'h9F;

   localparam int STAT_WIP = 0;
   localparam int STAT_WEL = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_PROG,
      ST_ID,
      ST_STAT,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Brings the asynchronous SPI pins into the clk_48mhz domain and derives
// one-cycle rise/fall strobes for sck plus settled levels for cs and mosi.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sck_pin,
   input  logic cs_pin,
   input  logic mosi_pin,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_level,
   output logic mosi_level
);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_prev;

   // cs resets to its deasserted level so the responder starts deselected.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every stage a real flop; blocking would collapse the chain.
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_pin};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
         sck_prev  <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign sck_rise   =  sck_sync[SYNC_STAGES-1] & ~sck_prev;
   assign sck_fall   = ~sck_sync[SYNC_STAGES-1] &  sck_prev;
   assign cs_level   = cs_sync[SYNC_STAGES-1];
   assign mosi_level = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash stand-in: decodes READ, PROG, RDID, RDSR, WREN
// and WRDI and serves data from an external byte-wide memory port.
module spi_flash_responder #(
   parameter int          ADDR_W      = 20,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4014,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              clk_48mhz,
   input  logic              reset_n,
   input  logic              spi_cs,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   output logic              busy
);
   import spi_flash_pkg::*;

   logic sck_rise, sck_fall, cs_level, mosi_level;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk_48mhz),
      .reset_n    (reset_n),
      .sck_pin    (spi_sck),
      .cs_pin     (spi_cs),
      .mosi_pin   (spi_mosi),
      .sck_rise   (sck_rise),
      .sck_fall   (sck_fall),
      .cs_level   (cs_level),
      .mosi_level (mosi_level)
   );

   state_t      state, state_n;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_shift;
   logic [7:0]  tx_shift, tx_next, status;
   logic        reload_pend;
   logic [1:0]  addr_cnt, id_idx;
   logic        is_prog, wel;
   logic        wr_pend, rd_cap;
   logic [7:0]  rd_buf;

   logic       cs_active, rise_ok, fall_ok, byte_done;
   logic [7:0] rx_byte;

   // Strobes arriving together with a cs release are dropped by gating on cs.
   assign cs_active = ~cs_level;
   assign rise_ok   = sck_rise & cs_active;
   assign fall_ok   = sck_fall & cs_active;
   assign byte_done = rise_ok && (bit_cnt == 3'd7);
   assign rx_byte   = {rx_shift, mosi_level};

   assign spi_miso    = tx_shift[7];
   assign spi_miso_oe = cs_active;
   assign busy        = cs_active;

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_n = state;
      status  = '0;
      tx_next = '0;
      status[STAT_WEL] = wel;
      status[STAT_WIP] = 1'b0;
      case (state)
         ST_IDLE: if (cs_active) state_n = ST_CMD;
         ST_CMD: begin
            if (byte_done) begin
               case (rx_byte)
                  OP_READ: state_n = ST_ADDR;
                  OP_PROG: state_n = wel ? ST_ADDR : ST_IGNORE;
                  OP_RDID: state_n = ST_ID;
                  OP_RDSR: state_n = ST_STAT;
                  default: state_n = ST_IGNORE;
               endcase
            end
         end
         ST_ADDR: if (byte_done && addr_cnt == 2'd2) state_n = is_prog ? ST_PROG : ST_READ;
         default: ;
      endcase
      if (!cs_active) state_n = ST_IDLE;

      case (state)
         ST_ID: begin
            case (id_idx)
               2'd0:    tx_next = JEDEC_ID[23:16];
               2'd1:    tx_next = JEDEC_ID[15:8];
               2'd2:    tx_next = JEDEC_ID[7:0];
               default: tx_next = 8'h00;
            endcase
         end
         ST_STAT: tx_next = status;
         ST_READ: tx_next = rd_buf;
         default: tx_next = 8'h00;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         reload_pend <= 1'b0;
         addr_cnt    <= '0;
         id_idx      <= '0;
         is_prog     <= 1'b0;
         wel         <= 1'b0;
         wr_pend     <= 1'b0;
         rd_cap      <= 1'b0;
         rd_buf      <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         mem_rd  <= 1'b0;
         mem_wr  <= wr_pend;
         wr_pend <= 1'b0;
         rd_cap  <= mem_rd;
         if (rd_cap) rd_buf <= mem_rdata;
         // Page program wraps inside the 256-byte page.
         if (mem_wr) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

         if (!cs_active) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            reload_pend <= 1'b0;
            addr_cnt    <= '0;
            id_idx      <= '0;
            if (state == ST_PROG) wel <= 1'b0;
         end else begin
            if (rise_ok) begin
               rx_shift <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
               reload_pend <= 1'b1;
               case (state)
                  ST_CMD: begin
                     is_prog <= (rx_byte == OP_PROG);
                     if (rx_byte == OP_WREN) wel <= 1'b1;
                     if (rx_byte == OP_WRDI) wel <= 1'b0;
                  end
                  ST_ADDR: begin
                     // Shifting bytes in leaves the low ADDR_W bits of the 24-bit address.
                     addr_cnt <= addr_cnt + 2'd1;
                     mem_addr <= ADDR_W'({mem_addr, rx_byte});
                     if (addr_cnt == 2'd2 && !is_prog) mem_rd <= 1'b1;
                  end
                  ST_READ: begin
                     mem_addr <= mem_addr + ADDR_W'(1);
                     mem_rd   <= 1'b1;
                  end
                  ST_PROG: begin
                     mem_wdata <= rx_byte;
                     wr_pend   <= 1'b1;
                  end
                  default: ;
               endcase
            end
            if (fall_ok) begin
               if (reload_pend) begin
                  tx_shift    <= tx_next;
                  reload_pend <= 1'b0;
                  if (state == ST_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
               end else begin
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged mode-0 SPI master at
// clk/8 plus a byte-wide memory model that logs every strobe.
module tb_spi_flash_responder;

   localparam int ADDR_W = 20;

   logic              clk_48mhz = 1'b0;
   logic              reset_n   = 1'b0;
   logic              spi_cs    = 1'b1;
   logic              spi_sck   = 1'b0;
   logic              spi_mosi  = 1'b0;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata = 8'h00;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic              busy;

   int total = 0;
   int bad   = 0;

   spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4014), .SYNC_STAGES(2)) dut (
      .clk_48mhz   (clk_48mhz),
      .reset_n     (reset_n),
      .spi_cs      (spi_cs),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .mem_wr      (mem_wr),
      .mem_wdata   (mem_wdata),
      .busy        (busy)
   );

   always #10 clk_48mhz = ~clk_48mhz;

   // Memory model: read data appears the cycle after mem_rd; writes are logged.
   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   int                rd_count = 0;
   int                wr_count = 0;
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [7:0]        wr_data_q [$];

   always @(posedge clk_48mhz) begin
      if (mem_rd) begin
         mem_rdata <= mem[mem_addr];
         rd_count  <= rd_count + 1;
      end
      if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
         wr_count      <= wr_count + 1;
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_48mhz);
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      wait_clk(4);
   endtask

   task automatic cs_high();
      wait_clk(4);
      spi_cs = 1'b1;
      wait_clk(6);
   endtask

   // Shifts nbits of tx out MSB first, capturing MISO before each rising sck.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         wait_clk(4);
         rx[7-i] = spi_miso;
         spi_sck = 1'b1;
         wait_clk(4);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_xfer(tx, 8, rx);
   endtask

   task automatic single_cmd(input logic [7:0] op);
      logic [7:0] rx;
      cs_low();
      spi_byte(op, rx);
      cs_high();
   endtask

   task automatic read_status(output logic [7:0] st);
      logic [7:0] rx;
      cs_low();
      spi_byte(8'h05, rx);
      spi_byte(8'h00, st);
      cs_high();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(1);
      total++; if (spi_miso !== 1'b0)    begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
      total++; if (mem_rd !== 1'b0)      begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
      total++; if (mem_wr !== 1'b0)      begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
      total++; if (mem_addr !== '0)      begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      total++; if (mem_wdata !== 8'h00)  begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_jedec();
      logic [7:0] rx;
      logic [7:0] exp [4];
      exp[0] = 8'hEF; exp[1] = 8'h40; exp[2] = 8'h14; exp[3] = 8'h00;
      cs_low();
      total++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1)
         begin bad++; $display("FAIL jedec_busy_oe got=%b%b exp=11", busy, spi_miso_oe); end
      spi_byte(8'h9F, rx);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'h00, rx);
         total++; if (rx !== exp[i]) begin bad++; $display("FAIL jedec_byte%0d got=%h exp=%h", i, rx, exp[i]); end
      end
      cs_high();
   endtask

   task automatic test_read_wrap();
      logic [7:0] rx;
      logic [7:0] exp [3];
      exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
      mem[20'hFFFFE] = 8'hA1;
      mem[20'hFFFFF] = 8'hB2;
      mem[20'h00000] = 8'hC3;
      cs_low();
      spi_byte(8'h03, rx);
      spi_byte(8'h0F, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hFE, rx);
      for (int i = 0; i < 3; i++) begin
         spi_byte(8'h00, rx);
         total++; if (rx !== exp[i]) begin bad++; $display("FAIL read_byte%0d got=%h exp=%h", i, rx, exp[i]); end
      end
      cs_high();
   endtask

   task automatic test_prog();
      logic [7:0] rx, st;
      int         w0;
      w0 = wr_count;
      cs_low();
      spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h01, rx); spi_byte(8'h00, rx);
      spi_byte(8'h55, rx);
      cs_high();
      total++; if (wr_count !== w0) begin bad++; $display("FAIL prog_no_wren writes got=%0d exp=%0d", wr_count, w0); end

      single_cmd(8'h06);
      read_status(st);
      total++; if (st !== 8'h02) begin bad++; $display("FAIL status_wel got=%h exp=02", st); end

      w0 = wr_count;
      cs_low();
      spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h01, rx); spi_byte(8'hFF, rx);
      spi_byte(8'h11, rx); spi_byte(8'h22, rx);
      cs_high();
      total++; if (wr_count !== w0 + 2) begin bad++; $display("FAIL prog_count got=%0d exp=%0d", wr_count - w0, 2); end
      if (wr_addr_q.size() >= 2) begin
         total++; if (wr_addr_q[0] !== 20'h001FF || wr_data_q[0] !== 8'h11)
            begin bad++; $display("FAIL prog_wr0 got=%h:%h exp=001ff:11", wr_addr_q[0], wr_data_q[0]); end
         total++; if (wr_addr_q[1] !== 20'h00100 || wr_data_q[1] !== 8'h22)
            begin bad++; $display("FAIL prog_wr1 got=%h:%h exp=00100:22", wr_addr_q[1], wr_data_q[1]); end
      end else begin
         total++; bad++; $display("FAIL prog_log got=%0d entries exp=2", wr_addr_q.size());
      end
      read_status(st);
      total++; if (st !== 8'h00) begin bad++; $display("FAIL status_after_prog got=%h exp=00", st); end
   endtask

   task automatic test_abort();
      logic [7:0] rx, st;
      int         w0;
      single_cmd(8'h06);
      w0 = wr_count;
      cs_low();
      spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
      spi_xfer(8'hAA, 5, rx);
      cs_high();
      wait_clk(4);
      total++; if (wr_count !== w0) begin bad++; $display("FAIL abort_writes got=%0d exp=%0d", wr_count, w0); end
      total++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0)
         begin bad++; $display("FAIL abort_idle got=%b%b exp=00", busy, spi_miso_oe); end
      read_status(st);
      total++; if (st !== 8'h00) begin bad++; $display("FAIL abort_status got=%h exp=00", st); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      cs_low();
      spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
      spi_xfer(8'h00, 3, rx);
      reset_n = 1'b0;
      @(posedge clk_48mhz);
      #1;
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL midreset_oe got=%b exp=0", spi_miso_oe); end
      total++; if (mem_rd !== 1'b0)      begin bad++; $display("FAIL midreset_mem_rd got=%b exp=0", mem_rd); end
      @(negedge clk_48mhz);
      reset_n = 1'b1;
      wait_clk(4);
      spi_cs = 1'b1;
      wait_clk(8);
      cs_low();
      spi_byte(8'h9F, rx);
      spi_byte(8'h00, rx);
      cs_high();
      total++; if (rx !== 8'hEF) begin bad++; $display("FAIL midreset_jedec got=%h exp=ef", rx); end
   endtask

   task automatic test_wel_and_unknown();
      logic [7:0] rx, st;
      int         r0, w0;
      single_cmd(8'h06);
      single_cmd(8'h04);
      read_status(st);
      total++; if (st !== 8'h00) begin bad++; $display("FAIL wrdi_status got=%h exp=00", st); end

      r0 = rd_count;
      w0 = wr_count;
      cs_low();
      spi_byte(8'hAB, rx);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'hFF, rx);
         total++; if (rx !== 8'h00) begin bad++; $display("FAIL unknown_miso%0d got=%h exp=00", i, rx); end
      end
      cs_high();
      total++; if (rd_count !== r0 || wr_count !== w0)
         begin bad++; $display("FAIL unknown_strobes got=rd%0d/wr%0d exp=rd%0d/wr%0d", rd_count, wr_count, r0, w0); end
   endtask

   initial begin
      test_reset();
      test_jedec();
      test_read_wrap();
      test_prog();
      test_abort();
      test_reset_mid();
      test_wel_and_unknown();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
